// File: rtl/fft_frame_buffer.sv
// -----------------------------------------------------------------------------
// fft_frame_buffer
//   Collects a stream of unsigned audio samples into an 8-deep sliding history
//   and presents 8-sample frames to a downstream FFT stage with a valid/ready
//   handshake. The source is never back-pressured: a frame that falls due while
//   the previous one is still unaccepted is dropped and flagged on overrun.
//
//   Configuration macro: FRAME_OVERLAP_EN
//     undefined : a frame every 8 samples (non-overlapping)
//     defined   : a frame every 4 samples once the history is full (50% overlap)
//   The first frame after reset always needs 8 samples.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous, active-high reset
//   sample_in     in   DATA_W  unsigned sample, captured when sample_valid=1
//   sample_valid  in   qualifies sample_in
//   frame_ready   in   downstream accepts the presented frame
//   x_0..x_7      out  DATA_W  frame snapshot, x_0 oldest, x_7 newest
//   frame_valid   out  x_0..x_7 hold a valid, not-yet-accepted frame
//   overrun       out  one-cycle pulse when a due frame is dropped
// -----------------------------------------------------------------------------
module fft_frame_buffer #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              frame_ready,
    output logic [DATA_W-1:0] x_0,
    output logic [DATA_W-1:0] x_1,
    output logic [DATA_W-1:0] x_2,
    output logic [DATA_W-1:0] x_3,
    output logic [DATA_W-1:0] x_4,
    output logic [DATA_W-1:0] x_5,
    output logic [DATA_W-1:0] x_6,
    output logic [DATA_W-1:0] x_7,
    output logic              frame_valid,
    output logic              overrun
);

    localparam int unsigned CNT_W = 4;
`ifdef FRAME_OVERLAP_EN
    localparam int unsigned HOP = 4;
`else
    localparam int unsigned HOP = 8;
`endif

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hist_q [FRAME_LEN];
    logic [DATA_W-1:0] hist_d [FRAME_LEN];
    logic [DATA_W-1:0] snap_q [FRAME_LEN];
    logic [DATA_W-1:0] snap_d [FRAME_LEN];
    logic              fv_q, fv_d;
    logic              ovr_q, ovr_d;
    logic              due_c;
    logic              xfer_c;

    // Next-state: history shift, frame-due detection, handshake and drop logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        snap_d  = snap_q;
        fv_d    = fv_q;
        ovr_d   = 1'b0;
        due_c   = 1'b0;
        xfer_c  = fv_q & frame_ready;

        if (sample_valid) begin
            for (int unsigned i = 0; i < FRAME_LEN - 1; i++) begin
                hist_d[i] = hist_q[i+1];
            end
            hist_d[FRAME_LEN-1] = sample_in;
            cnt_d = cnt_q + CNT_W'(1);

            // FILL always waits for a full history; RUN emits every HOP samples.
            if (state_q == S_FILL) begin
                if (cnt_d == CNT_W'(FRAME_LEN)) begin
                    due_c   = 1'b1;
                    state_d = S_RUN;
                end
            end else if (cnt_d == CNT_W'(HOP)) begin
                due_c = 1'b1;
            end
        end

        if (due_c) begin
            // A dropped frame still restarts the hop count.
            cnt_d = '0;
            if (!fv_q || xfer_c) begin
                snap_d = hist_d;
                fv_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (xfer_c) begin
            fv_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                hist_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            ovr_q   <= ovr_d;
            for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                hist_q[i] <= hist_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign x_0         = snap_q[0];
    assign x_1         = snap_q[1];
    assign x_2         = snap_q[2];
    assign x_3         = snap_q[3];
    assign x_4         = snap_q[4];
    assign x_5         = snap_q[5];
    assign x_6         = snap_q[6];
    assign x_7         = snap_q[7];
    assign frame_valid = fv_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
module tb_fft_frame_buffer;

    localparam int DW = 12;
`ifdef FRAME_OVERLAP_EN
    localparam int HOP = 4;
`else
    localparam int HOP = 8;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          frame_ready;
    logic [DW-1:0] x [8];
    logic          frame_valid;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    fft_frame_buffer #(.DATA_W(DW), .FRAME_LEN(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .frame_ready  (frame_ready),
        .x_0          (x[0]),
        .x_1          (x[1]),
        .x_2          (x[2]),
        .x_3          (x[3]),
        .x_4          (x[4]),
        .x_5          (x[5]),
        .x_6          (x[6]),
        .x_7          (x[7]),
        .frame_valid  (frame_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a queue holding the last 8 samples and a count of
    // samples since the last frame.
    int m_hist[$];
    int m_x[8];
    bit m_fv;
    bit m_ovr;
    bit m_filled;
    int m_k;

    function automatic void model_reset();
        m_hist = {};
        for (int i = 0; i < 8; i++) begin
            m_hist.push_back(0);
            m_x[i] = 0;
        end
        m_fv = 0;
        m_ovr = 0;
        m_filled = 0;
        m_k = 0;
    endfunction

    function automatic void model_step(bit r, bit v, int s, bit rd);
        bit xfer;
        bit due;
        if (r) begin
            model_reset();
            return;
        end
        xfer  = m_fv && rd;
        due   = 0;
        m_ovr = 0;
        if (v) begin
            m_hist.push_back(s);
            void'(m_hist.pop_front());
            m_k++;
            if (!m_filled && m_k == 8) begin
                due = 1;
                m_filled = 1;
            end else if (m_filled && m_k == HOP) begin
                due = 1;
            end
        end
        if (due) begin
            m_k = 0;
            if (!m_fv || xfer) begin
                for (int i = 0; i < 8; i++) m_x[i] = m_hist[i];
                m_fv = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (xfer) begin
            m_fv = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs with the model.
    task automatic step(input bit r, input bit v, input int s, input bit rd);
        rst          = r;
        sample_valid = v;
        sample_in    = DW'(s);
        frame_ready  = rd;
        @(posedge clk);
        model_step(r, v, s, rd);
        #1;
        chk("model frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("model overrun", 32'(overrun), 32'(m_ovr));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("model x_%0d", i), 32'(x[i]), 32'(m_x[i]));
        end
    endtask

    typedef struct {
        bit r;
        bit v;
        int s;
        bit rd;
        bit efv;
        bit eovr;
        int ex0;
        int ex7;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        frame_ready = 1'b0;
        model_reset();

        // Directed table: reset, then samples 1..8 with ready high.
        tbl[0] = '{r:1, v:0, s:0, rd:1, efv:0, eovr:0, ex0:0, ex7:0};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{r:0, v:1, s:i, rd:1, efv:(i == 8), eovr:0,
                       ex0:(i == 8) ? 1 : 0, ex7:(i == 8) ? 8 : 0};
        end
        tbl[9] = '{r:0, v:0, s:0, rd:1, efv:0, eovr:0, ex0:1, ex7:8};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].rd);
            chk($sformatf("tbl[%0d] frame_valid", i), 32'(frame_valid), 32'(tbl[i].efv));
            chk($sformatf("tbl[%0d] overrun", i), 32'(overrun), 32'(tbl[i].eovr));
            chk($sformatf("tbl[%0d] x_0", i), 32'(x[0]), 32'(tbl[i].ex0));
            chk($sformatf("tbl[%0d] x_7", i), 32'(x[7]), 32'(tbl[i].ex7));
        end

        // Held frame with ready low; next due frame is dropped with one overrun.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 8 + HOP; i++) begin
            step(0, 1, i, 0);
            if (i >= 8) begin
                chk("hold frame_valid", 32'(frame_valid), 32'd1);
                chk("hold x_0", 32'(x[0]), 32'd1);
                chk("hold x_7", 32'(x[7]), 32'd8);
                chk("hold overrun", 32'(overrun), (i == 8 + HOP) ? 32'd1 : 32'd0);
            end
        end
        step(0, 0, 0, 0);
        chk("overrun one-cycle", 32'(overrun), 32'd0);
        chk("dropped frame absent x_7", 32'(x[7]), 32'd8);

        // Transfer coincides with a due frame: new frame loads, no overrun.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 8 + HOP; i++) step(0, 1, i, (i == 8 + HOP));
        chk("coinc frame_valid", 32'(frame_valid), 32'd1);
        chk("coinc x_0", 32'(x[0]), 32'(1 + HOP));
        chk("coinc x_7", 32'(x[7]), 32'(8 + HOP));
        chk("coinc overrun", 32'(overrun), 32'd0);
        step(0, 0, 0, 1);
        chk("coinc drain", 32'(frame_valid), 32'd0);

        // Reset after 5 samples; refill needs 8 fresh samples.
        step(1, 0, 0, 1);
        for (int i = 1; i <= 5; i++) step(0, 1, i, 1);
        step(1, 1, 55, 1);
        chk("midreset frame_valid", 32'(frame_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 100 + i, 1);
            chk("refill frame_valid", 32'(frame_valid), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("refill x_0", 32'(x[0]), 32'd100);
        chk("refill x_7", 32'(x[7]), 32'd107);

        // Reset while a frame is pending: no overrun, frame discarded.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("pending reset fv", 32'(frame_valid), 32'd0);
        chk("pending reset ovr", 32'(overrun), 32'd0);

        // sample_valid toggling.
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, i, 1);
            chk("toggle fv after valid", 32'(frame_valid), (i == 8) ? 32'd1 : 32'd0);
            if (i == 8) begin
                chk("toggle x_0", 32'(x[0]), 32'd1);
                chk("toggle x_7", 32'(x[7]), 32'd8);
            end
            step(0, 0, 0, 1);
            chk("toggle fv after bubble", 32'(frame_valid), 32'd0);
        end

        // Randomized traffic against the model.
        step(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 150) == 0, ($urandom % 4) != 0,
                 int'($urandom % 4096), ($urandom % 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_buffer.md
FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 12, sample and output word width in bits.
REQ-002 Parameter FRAME_LEN, fixed at 8, samples per frame; no other value is supported.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port sample_in  input  DATA_W  audio sample; captured only when sample_valid=1.
REQ-006 Port sample_valid  input  1  qualifies sample_in, one sample per cycle maximum.
REQ-007 Port frame_ready  input  1  downstream FFT stage accepts the presented frame.
REQ-008 Ports x_0..x_7  output  DATA_W each  frame snapshot; x_0 is the oldest sample, x_7 the newest.
REQ-009 Port frame_valid  output  1  x_0..x_7 hold a valid, not-yet-accepted frame.
REQ-010 Port overrun  output  1  one-cycle pulse when a due frame is dropped.

Function
REQ-011 A sample SHALL be accepted in every cycle with sample_valid=1, irrespective of frame_valid or frame_ready; the block never back-pressures the source.
REQ-012 Accepted samples SHALL shift into an internal 8-deep history register: newest at position 7, all entries move down one, and the oldest is discarded.
REQ-013 A new-sample counter (0..8) SHALL increment on each accepted sample and SHALL clear when a frame becomes due.
REQ-014 States: FILL (after reset, fewer than 8 samples since reset) and RUN (history full).
REQ-015 FILL -> RUN on the 8th accepted sample. That sample makes the first frame due.
REQ-016 In RUN, a frame SHALL be due on the accepted sample that brings the counter to HOP, where HOP is defined in REQ-026.
REQ-017 When a frame is due, the snapshot SHALL be the history including the current sample. x_0..x_7 and frame_valid=1 SHALL appear on the cycle after that sample's acceptance, for a latency of 1.
REQ-018 The handshake SHALL transfer the frame in a cycle where frame_valid=1 and frame_ready=1. If no frame is due in that cycle, frame_valid SHALL go to 0 on the next cycle.
REQ-019 x_0..x_7 SHALL remain stable while frame_valid=1 and frame_ready=0.
REQ-020 A due frame that coincides with a transfer SHALL load the snapshot, keep frame_valid=1, and SHALL NOT pulse overrun.
REQ-021 A due frame while frame_valid=1 and frame_ready=0 SHALL be dropped: the snapshot is unchanged, overrun=1 for one cycle, and the counter clears as if the frame had been emitted.
REQ-022 frame_ready while frame_valid=0 SHALL have no effect.
REQ-023 Samples are unsigned and passed through unmodified; there is no arithmetic or width change.

Reset
REQ-024 While rst=1 at a clock edge, the following SHALL be cleared: x_0..x_7=0, frame_valid=0, overrun=0, history=0, counter=0, and state=FILL. Any sample_valid in that cycle SHALL be ignored.
REQ-025 rst mid-frame or mid-handshake SHALL discard any pending frame without an overrun pulse. Refill SHALL require 8 new samples.

Configuration
REQ-026 Macro FRAME_OVERLAP_EN: if defined, HOP=4 (50% overlap, a frame every 4 samples in RUN); if undefined, HOP=8 (non-overlapping frames).
REQ-027 The first frame after reset SHALL always require 8 samples, regardless of FRAME_OVERLAP_EN.

Verification
REQ-028 Scenario: without the macro, after reset feed samples 1..8 with frame_ready=1 -> the cycle after sample 8, frame_valid=1 with x_0=1 and x_7=8, and frame_valid=0 on the following cycle.
REQ-029 Scenario: FRAME_OVERLAP_EN defined, feed samples 1..12 with frame_ready=1 -> frame {1..8} is followed by frame {5..12} one cycle after sample 12.
REQ-030 Scenario: without the macro, frame_ready=0 while feeding samples 1..16 -> frame {1..8} is held stable, overrun pulses once on the cycle after sample 16, and no frame {9..16} appears.
REQ-031 Scenario: FRAME_OVERLAP_EN defined, frame_ready=1 exactly in the cycle that sample 12 is accepted, while frame {1..8} is pending -> frame_valid stays 1, x_0..x_7 becomes {5..12}, and there is no overrun.
REQ-032 Scenario: assert rst after 5 samples, then feed samples 100..107 -> there is no frame before sample 107, and the frame is {100..107}.
REQ-033 Scenario: sample_valid toggling 1/0 each cycle over samples 1..8 -> the frame is {1..8}, and frame_valid asserts one cycle after the 8th accepted sample.
